// File: rtl/cae_inst_pkg.sv
// cae_inst_pkg: opcode/function constants and decode record for the dispatch decoder
package cae_inst_pkg;
    localparam int AEG_IDX_W = 18;
    localparam int CAEP_W    = 5;

    localparam logic [3:0] OPC_F7_GRP = 4'b1101;
    localparam logic [4:0] OPC_F6_WR  = 5'b11100;
    localparam logic [4:0] OPC_F5_RD  = 5'b11101;
    localparam logic [4:0] OPC_CAEP   = 5'b11110;

    localparam logic [6:0] FN_MOV_AEG_WR     = 7'h40;
    localparam logic [6:0] FN_MOV_AEG_RD_IND = 7'h68;
    localparam logic [6:0] FN_MOV_AEG_RD     = 7'h70;
    localparam logic [5:0] FN_WR_A           = 6'h18;
    localparam logic [5:0] FN_WR_B           = 6'h20;
    localparam logic [5:0] FN_RD             = 6'h1C;

    typedef struct packed {
        logic                 val;
        logic [CAEP_W-1:0]    caep;
        logic                 wr;
        logic                 rd;
        logic [AEG_IDX_W-1:0] idx;
        logic                 err;
    } dec_t;
endpackage

// File: rtl/cae_inst_decoder.sv
// cae_inst_decoder: decodes dispatched coprocessor instructions into one-hot strobes
// clk, i_reset           : clock, synchronous active-high reset
// cae_inst, cae_data     : instruction word and scalar data (data[17:0] for indirect AEG reads)
// cae_inst_vld           : instruction valid, one cycle per instruction
// inst_val, inst_caep    : custom CAEP instruction valid and number
// inst_aeg_wr/rd, idx    : AEG write/read strobes and register index
// err_unimpl             : unimplemented or illegal instruction
module cae_inst_decoder
    import cae_inst_pkg::*;
#(
    parameter bit OUT_REG = 0
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic [31:0]          cae_inst,
    input  logic [63:0]          cae_data,
    input  logic                 cae_inst_vld,
    output logic                 inst_val,
    output logic [CAEP_W-1:0]    inst_caep,
    output logic                 inst_aeg_wr,
    output logic                 inst_aeg_rd,
    output logic [AEG_IDX_W-1:0] inst_aeg_idx,
    output logic                 err_unimpl
);
    logic [4:0] opc;
    logic [5:0] fn6;
    logic [6:0] fn7;
    dec_t       d;
    dec_t       o;
    logic       unused;

    assign opc    = cae_inst[28:24];
    assign fn6    = cae_inst[23:18];
    assign fn7    = cae_inst[24:18];
    assign unused = ^{clk, cae_inst[31:29], cae_data[63:18]};

    always_comb begin
        d = '0;
        if (cae_inst_vld) begin
            if (opc[4:1] == OPC_F7_GRP) begin
                d.wr  = fn7 == FN_MOV_AEG_WR;
                d.rd  = fn7 == FN_MOV_AEG_RD_IND || fn7 == FN_MOV_AEG_RD;
                d.err = !(d.wr || d.rd);
                d.idx = fn7 == FN_MOV_AEG_WR     ? cae_inst[17:0] :
                        fn7 == FN_MOV_AEG_RD_IND ? cae_data[17:0] :
                        fn7 == FN_MOV_AEG_RD     ? {6'b0, cae_inst[17:6]} : '0;
            end else if (opc == OPC_F6_WR) begin
                d.wr  = fn6 == FN_WR_A || fn6 == FN_WR_B;
                d.err = !d.wr;
                d.idx = d.wr ? {6'b0, cae_inst[17:12], cae_inst[5:0]} : '0;
            end else if (opc == OPC_F5_RD) begin
                d.rd  = fn6 == FN_RD;
                d.err = !d.rd;
                d.idx = d.rd ? {6'b0, cae_inst[17:6]} : '0;
            end else if (opc == OPC_CAEP) begin
                d.val  = fn6[5];
                d.err  = !fn6[5];
                d.caep = fn6[5] ? fn6[4:0] : '0;
            end else begin
                d.err = 1'b1;
            end
        end
    end

    generate
        if (OUT_REG) begin : g_reg
            dec_t q;
            always_ff @(posedge clk) begin
                if (i_reset) q <= '0;
                else         q <= d;
            end
            assign o = q;
        end else begin : g_comb
            assign o = i_reset ? '0 : d;
        end
    endgenerate

    assign inst_val     = o.val;
    assign inst_caep    = o.caep;
    assign inst_aeg_wr  = o.wr;
    assign inst_aeg_rd  = o.rd;
    assign inst_aeg_idx = o.idx;
    assign err_unimpl   = o.err;
endmodule

// File: tb/tb_cae_inst_decoder.sv
// tb_cae_inst_decoder: directed checks of combinational and registered decoder variants
module tb_cae_inst_decoder;
    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] cae_inst;
    logic [63:0] cae_data;
    logic        cae_inst_vld;

    logic        c_val, c_wr, c_rd, c_err, r_val, r_wr, r_rd, r_err;
    logic [4:0]  c_caep, r_caep;
    logic [17:0] c_idx, r_idx;
    logic [26:0] c_out, r_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cae_inst_decoder #(.OUT_REG(0)) u_comb (
        .clk(clk), .i_reset(i_reset), .cae_inst(cae_inst), .cae_data(cae_data),
        .cae_inst_vld(cae_inst_vld), .inst_val(c_val), .inst_caep(c_caep),
        .inst_aeg_wr(c_wr), .inst_aeg_rd(c_rd), .inst_aeg_idx(c_idx), .err_unimpl(c_err)
    );

    cae_inst_decoder #(.OUT_REG(1)) u_reg (
        .clk(clk), .i_reset(i_reset), .cae_inst(cae_inst), .cae_data(cae_data),
        .cae_inst_vld(cae_inst_vld), .inst_val(r_val), .inst_caep(r_caep),
        .inst_aeg_wr(r_wr), .inst_aeg_rd(r_rd), .inst_aeg_idx(r_idx), .err_unimpl(r_err)
    );

    assign c_out = {c_val, c_caep, c_wr, c_rd, c_idx, c_err};
    assign r_out = {r_val, r_caep, r_wr, r_rd, r_idx, r_err};

    function automatic logic [26:0] mk(input logic v, input logic [4:0] cp, input logic w,
                                       input logic r, input logic [17:0] ix, input logic e);
        return {v, cp, w, r, ix, e};
    endfunction

    task automatic drive(input logic [31:0] i, input logic [63:0] dt, input logic v);
        @(negedge clk);
        cae_inst = i;
        cae_data = dt;
        cae_inst_vld = v;
        #2;
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        drive(32'h1E800000, 64'h0, 1'b1);
        checks++;
        if (c_out !== 27'd0) begin
            failures++;
            $display("FAIL reset_comb got=%h exp=%h", c_out, 27'd0);
        end
        @(posedge clk); #1;
        checks++;
        if (r_out !== 27'd0) begin
            failures++;
            $display("FAIL reset_reg got=%h exp=%h", r_out, 27'd0);
        end
        drive(32'h0, 64'h0, 1'b0);
        i_reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors;
        logic [31:0] ins [11];
        logic [63:0] dat [11];
        logic        vld [11];
        logic [26:0] exp [11];
        ins[0]  = 32'h1E800000; dat[0]  = 64'h0;  vld[0]  = 1; exp[0]  = mk(1, 5'd0, 0, 0, 18'h0, 0);
        ins[1]  = 32'h1E940000; dat[1]  = 64'h0;  vld[1]  = 1; exp[1]  = mk(1, 5'd5, 0, 0, 18'h0, 0);
        ins[2]  = 32'h1B000005; dat[2]  = 64'h0;  vld[2]  = 1; exp[2]  = mk(0, 5'd0, 1, 0, 18'h5, 0);
        ins[3]  = 32'h1B000005; dat[3]  = 64'h0;  vld[3]  = 0; exp[3]  = 27'd0;
        ins[4]  = 32'h1BA00000; dat[4]  = 64'hFFFF_FFFF_FFFC_0032; vld[4] = 1; exp[4] = mk(0, 5'd0, 0, 1, 18'h32, 0);
        ins[5]  = 32'h1BC001C0; dat[5]  = 64'h0;  vld[5]  = 1; exp[5]  = mk(0, 5'd0, 0, 1, 18'h7, 0);
        ins[6]  = 32'h1D7000C0; dat[6]  = 64'h0;  vld[6]  = 1; exp[6]  = mk(0, 5'd0, 0, 1, 18'h3, 0);
        ins[7]  = 32'h1C601002; dat[7]  = 64'h0;  vld[7]  = 1; exp[7]  = mk(0, 5'd0, 1, 0, 18'h42, 0);
        ins[8]  = 32'h1E400000; dat[8]  = 64'h0;  vld[8]  = 1; exp[8]  = mk(0, 5'd0, 0, 0, 18'h0, 1);
        ins[9]  = 32'h1A000000; dat[9]  = 64'h0;  vld[9]  = 1; exp[9]  = mk(0, 5'd0, 0, 0, 18'h0, 1);
        ins[10] = 32'h00000000; dat[10] = 64'h0;  vld[10] = 1; exp[10] = mk(0, 5'd0, 0, 0, 18'h0, 1);
        for (int i = 0; i < 11; i++) begin
            drive(ins[i], dat[i], vld[i]);
            checks++;
            if (c_out !== exp[i]) begin
                failures++;
                $display("FAIL vec%0d_comb inst=%h got=%h exp=%h", i, ins[i], c_out, exp[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (r_out !== exp[i]) begin
                failures++;
                $display("FAIL vec%0d_reg inst=%h got=%h exp=%h", i, ins[i], r_out, exp[i]);
            end
        end
    endtask

    task automatic test_latency;
        drive(32'h0, 64'h0, 1'b0);
        @(posedge clk); #1;
        drive(32'h1E800000, 64'h0, 1'b1);
        checks++;
        if (r_out !== 27'd0) begin
            failures++;
            $display("FAIL latency_early got=%h exp=%h", r_out, 27'd0);
        end
        @(posedge clk); #1;
        checks++;
        if (r_out !== mk(1, 5'd0, 0, 0, 18'h0, 0)) begin
            failures++;
            $display("FAIL latency_n1 got=%h exp=%h", r_out, mk(1, 5'd0, 0, 0, 18'h0, 0));
        end
        drive(32'h1E800000, 64'h0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (r_out !== 27'd0) begin
            failures++;
            $display("FAIL latency_n2 got=%h exp=%h", r_out, 27'd0);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ins [3];
        logic [26:0] exp [3];
        ins[0] = 32'h1E940000; exp[0] = mk(1, 5'd5, 0, 0, 18'h0, 0);
        ins[1] = 32'h1D7000C0; exp[1] = mk(0, 5'd0, 0, 1, 18'h3, 0);
        ins[2] = 32'h1FFFFFFF; exp[2] = mk(0, 5'd0, 0, 0, 18'h0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], 64'h0, 1'b1);
            checks++;
            if (c_out !== exp[i]) begin
                failures++;
                $display("FAIL b2b%0d_comb got=%h exp=%h", i, c_out, exp[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (r_out !== exp[i]) begin
                failures++;
                $display("FAIL b2b%0d_reg got=%h exp=%h", i, r_out, exp[i]);
            end
        end
        i_reset = 1'b1;
        drive(32'h1C601002, 64'h0, 1'b1);
        checks++;
        if (c_out !== 27'd0) begin
            failures++;
            $display("FAIL b2b_reset_comb got=%h exp=%h", c_out, 27'd0);
        end
        @(posedge clk); #1;
        checks++;
        if (r_out !== 27'd0) begin
            failures++;
            $display("FAIL b2b_reset_reg got=%h exp=%h", r_out, 27'd0);
        end
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1;
        cae_inst = '0;
        cae_data = '0;
        cae_inst_vld = 1'b0;
        test_reset();
        test_vectors();
        test_latency();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
